// File: rtl/mult_seq_shift_add_if.sv
// Start/busy/done handshake and operand/product bus for mult_seq_shift_add.
interface mult_seq_shift_add_if #(
    parameter int unsigned SIZE = 16
);
    logic              iStart;
    logic [SIZE-1:0]   iA;
    logic [SIZE-1:0]   iB;
    logic              oBusy;
    logic              oDone;
    logic [2*SIZE-1:0] oResult;

    modport master (output iStart, iA, iB, input  oBusy, oDone, oResult);
    modport slave  (input  iStart, iA, iB, output oBusy, oDone, oResult);
endinterface

// File: rtl/mult_seq_shift_add.sv
// Iterative shift-and-add multiplier retiring one multiplier bit per clock.
// Build option MULT_SEQ_SIGNED_EN selects two's-complement operands (radix-2 Booth).
module mult_seq_shift_add #(
    parameter int unsigned SIZE = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    mult_seq_shift_add_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(SIZE + 1);
    localparam int unsigned PW    = 2 * SIZE;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    mcand, mcand_nxt;
    logic [PW-1:0]    acc, acc_nxt, acc_step;
    logic [PW-1:0]    result, result_nxt;
    logic [SIZE-1:0]  mplier, mplier_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy, busy_nxt;
    logic             done, done_nxt;
    logic [PW-1:0]    ext_a;
    logic             prev, prev_nxt;

`ifdef MULT_SEQ_SIGNED_EN
    assign ext_a = {{SIZE{bus.iA[SIZE-1]}}, bus.iA};

    // Booth pair {current LSB, previous LSB}: 01 adds, 10 subtracts
    always_comb begin
        acc_step = acc;
        case ({mplier[0], prev})
            2'b01:   acc_step = acc + mcand;
            2'b10:   acc_step = acc - mcand;
            default: acc_step = acc;
        endcase
    end
`else
    assign ext_a = {SIZE'(0), bus.iA};

    always_comb begin
        acc_step = mplier[0] ? (acc + mcand) : acc;
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        result_nxt = result;
        cnt_nxt    = cnt;
        prev_nxt   = prev;
        busy_nxt   = busy;
        done_nxt   = 1'b0;

        case (state)
            IDLE, DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
                if (bus.iStart) begin
                    mcand_nxt  = ext_a;
                    mplier_nxt = bus.iB;
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    prev_nxt   = 1'b0;
                    busy_nxt   = 1'b1;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                acc_nxt    = acc_step;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                prev_nxt   = mplier[0];
                cnt_nxt    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(SIZE - 1)) begin
                    result_nxt = acc_step;
                    busy_nxt   = 1'b0;
                    done_nxt   = 1'b1;
                    state_nxt  = DONE;
                end
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            result <= '0;
            cnt    <= '0;
            prev   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            result <= result_nxt;
            cnt    <= cnt_nxt;
            prev   <= prev_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    assign bus.oBusy   = busy;
    assign bus.oDone   = done;
    assign bus.oResult = result;
endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Scoreboard bench for mult_seq_shift_add at SIZE=16 and SIZE=8.
module tb_mult_seq_shift_add;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [63:0] q16[$];
    logic [63:0] q8[$];

    mult_seq_shift_add_if #(.SIZE(16)) bus16 ();
    mult_seq_shift_add_if #(.SIZE(8))  bus8  ();

    mult_seq_shift_add #(.SIZE(16)) dut16 (.Clock(Clock), .Reset(Reset), .bus(bus16));
    mult_seq_shift_add #(.SIZE(8))  dut8  (.Clock(Clock), .Reset(Reset), .bus(bus8));

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference product, truncated to 2*sz bits
    function automatic logic [63:0] model(input int sz, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask;
        longint      sa, sb;
        mask = (64'd1 << (2 * sz)) - 64'd1;
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
`ifdef MULT_SEQ_SIGNED_EN
        if (a[sz-1]) sa = sa - (64'sd1 <<< sz);
        if (b[sz-1]) sb = sb - (64'sd1 <<< sz);
`endif
        return 64'(sa * sb) & mask;
    endfunction

    // Scoreboard: every oDone pops one expected product
    always @(negedge Clock) begin
        if (bus16.oDone) begin
            chk("busy_at_done16", 64'(bus16.oBusy), 64'd0);
            if (q16.size() == 0) chk("unexp_done16", 64'd1, 64'd0);
            else chk("result16", 64'(bus16.oResult), q16.pop_front());
        end
        if (bus8.oDone) begin
            chk("busy_at_done8", 64'(bus8.oBusy), 64'd0);
            if (q8.size() == 0) chk("unexp_done8", 64'd1, 64'd0);
            else chk("result8", 64'(bus8.oResult), q8.pop_front());
        end
    end

    // Called at a negedge; pulses iStart for one cycle, optionally injects
    // stray iStart pulses while busy, and measures cycles to oDone.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit noise,
                        output int lat, output int busy_cnt);
        bus16.iStart = 1'b1;
        bus16.iA = a;
        bus16.iB = b;
        q16.push_back(model(16, 32'(a), 32'(b)));
        lat = 0;
        busy_cnt = 0;
        do begin
            @(negedge Clock);
            lat++;
            if (bus16.oBusy) busy_cnt++;
            bus16.iStart = noise && (lat == 3 || lat == 7);
            if (noise) bus16.iA = 16'h1234;
        end while (!bus16.oDone && lat < 100);
        bus16.iStart = 1'b0;
        if (!bus16.oDone) chk("timeout16", 64'd0, 64'd1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat);
        bus8.iStart = 1'b1;
        bus8.iA = a;
        bus8.iB = b;
        q8.push_back(model(8, 32'(a), 32'(b)));
        lat = 0;
        do begin
            @(negedge Clock);
            lat++;
            bus8.iStart = 1'b0;
        end while (!bus8.oDone && lat < 100);
        if (!bus8.oDone) chk("timeout8", 64'd0, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, t1, t2;
        bus16.iStart = 1'b0; bus16.iA = '0; bus16.iB = '0;
        bus8.iStart  = 1'b0; bus8.iA  = '0; bus8.iB  = '0;

        repeat (3) @(negedge Clock);
        chk("rst_busy", 64'(bus16.oBusy), 64'd0);
        chk("rst_done", 64'(bus16.oDone), 64'd0);
        chk("rst_result", 64'(bus16.oResult), 64'd0);
        chk("rst_result8", 64'(bus8.oResult), 64'd0);
        Reset = 1'b1;
        @(negedge Clock);

        // all-ones operands
        op16(16'hFFFF, 16'hFFFF, 1'b0, lat, bc);
        chk("lat_ffff", 64'(lat), 64'd17);
        chk("busy_cycles", 64'(bc), 64'd16);
`ifdef MULT_SEQ_SIGNED_EN
        chk("ffff_sq", 64'(bus16.oResult), 64'h1);
`else
        chk("ffff_sq", 64'(bus16.oResult), 64'hFFFE0001);
`endif
        repeat (4) @(negedge Clock);
        chk("hold_ffff", 64'(bus16.oResult), model(16, 32'hFFFF, 32'hFFFF));
        chk("idle_busy", 64'(bus16.oBusy), 64'd0);

        // SIZE=8: zero operand takes the same latency as non-zero
        op8(8'h00, 8'hA5, lat);
        chk("lat8_zero", 64'(lat), 64'd9);
        chk("zero8", 64'(bus8.oResult), 64'd0);
        @(negedge Clock);
        op8(8'hFF, 8'h81, lat);
        chk("lat8_nz", 64'(lat), 64'd9);

        // stray iStart pulses while busy are ignored
        @(negedge Clock);
        op16(16'h0003, 16'h0005, 1'b1, lat, bc);
        chk("lat_noise", 64'(lat), 64'd17);
        chk("res_3x5", 64'(bus16.oResult), 64'h0000000F);
        repeat (20) @(negedge Clock);
        chk("hold_3x5", 64'(bus16.oResult), 64'h0000000F);

        // asynchronous reset in the 5th busy cycle abandons the operation
        bus16.iStart = 1'b1; bus16.iA = 16'h00FF; bus16.iB = 16'h0100;
        @(negedge Clock);
        bus16.iStart = 1'b0;
        repeat (4) @(negedge Clock);
        chk("busy_before_rst", 64'(bus16.oBusy), 64'd1);
        #2 Reset = 1'b0;
        #1;
        chk("arst_busy", 64'(bus16.oBusy), 64'd0);
        chk("arst_done", 64'(bus16.oDone), 64'd0);
        chk("arst_result", 64'(bus16.oResult), 64'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        repeat (25) @(negedge Clock);
        chk("post_rst_idle", 64'(bus16.oBusy), 64'd0);
        op16(16'h0002, 16'h0002, 1'b0, lat, bc);
        chk("lat_2x2", 64'(lat), 64'd17);
        chk("res_2x2", 64'(bus16.oResult), 64'h00000004);

        // back-to-back: iStart held high through DONE
        @(negedge Clock);
        bus16.iStart = 1'b1; bus16.iA = 16'h0010; bus16.iB = 16'h0010;
        q16.push_back(model(16, 32'h10, 32'h10));
        lat = 0;
        do begin @(negedge Clock); lat++; end while (!bus16.oDone && lat < 100);
        t1 = cyc;
        chk("res_b2b1", 64'(bus16.oResult), 64'h00000100);
        bus16.iA = 16'h0020; bus16.iB = 16'h0002;
        q16.push_back(model(16, 32'h20, 32'h2));
        lat = 0;
        do begin @(negedge Clock); lat++; bus16.iStart = 1'b0; end
            while (!bus16.oDone && lat < 100);
        t2 = cyc;
        chk("b2b_gap", 64'(t2 - t1), 64'd17);
        chk("res_b2b2", 64'(bus16.oResult), 64'h00000040);

        // operands whose signed and unsigned products differ
        @(negedge Clock);
        op16(16'hFFFD, 16'h0005, 1'b0, lat, bc);
`ifdef MULT_SEQ_SIGNED_EN
        chk("neg3x5", 64'(bus16.oResult), 64'hFFFFFFF1);
`else
        chk("neg3x5", 64'(bus16.oResult), 64'h0004FFF1);
`endif
        @(negedge Clock);
        op16(16'h8000, 16'h8000, 1'b0, lat, bc);
        chk("min_sq", 64'(bus16.oResult), 64'h40000000);
        @(negedge Clock);
        op16(16'h7FFF, 16'h8001, 1'b0, lat, bc);

        repeat (25) @(negedge Clock);
        chk("q16_left", 64'(q16.size()), 64'd0);
        chk("q8_left", 64'(q8.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
